spi_reg_arbiter: RTL and testbench
==================================

Name: spi_reg_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared config/status register bank behind the SPI wrapper.
- Port 0 is the SPI transaction side; port 1 is an on-chip engine.
- The block serialises single-beat reads and writes onto one single-port bank interface with 1-cycle read latency.
- Ties are resolved round-robin; writes outside the writable config window are blocked.

Parameters:
- REG_WIDTH, 8: register data width.
- ADDR_W, 3: register address width (8 registers).
- WR_LIMIT, 2: writes allowed only to addr < WR_LIMIT (config regs); higher addresses are status, read-only.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ena  in  1  global enable; low freezes all state
- req0, req1  in  1  access request; hold until ack
- we0, we1  in  1  1=write, 0=read; hold with req
- addr0, addr1  in  ADDR_W  register address; hold with req
- wdata0, wdata1  in  REG_WIDTH  write data; hold with req
- ack0, ack1  out  1  one-cycle completion pulse
- rdata0, rdata1  out  REG_WIDTH  read data, valid while ackN=1
- err0, err1  out  1  high with ackN when a write was blocked (addr >= WR_LIMIT)
- bank_en  out  1  bank access strobe
- bank_we  out  1  bank write strobe
- bank_addr  out  ADDR_W  bank address
- bank_wdata  out  REG_WIDTH  bank write data
- bank_rdata  in  REG_WIDTH  bank read data, valid 1 cycle after bank_en
- conflict_cnt  out  8  saturating count of arbitration cycles with both req high

Behaviour:
- FSM states: IDLE, ACCESS, RESP. All outputs are decoded from registers.
- IDLE, no req: stay in IDLE.
- IDLE, any req: choose a winner, latch its we/addr/wdata, go to ACCESS.
- ACCESS: bank_en=1, bank_addr/bank_wdata = latched values. bank_we=1 only if latched we=1 and addr < WR_LIMIT. Go to RESP.
- RESP: ackN=1 for the winner only. rdataN = bank_rdata captured this cycle, and is also driven for writes. errN=1 iff the write was blocked. Go to IDLE.
- Latency: req high in an IDLE cycle n gives ACCESS at n+1 and ack at n+2. Throughput is one access per 3 cycles.
- Requester protocol: sample ack at the clock edge ending RESP and drop req (or present the next request) from the following cycle.
  - A req still high in the IDLE cycle after RESP is a new access. Back-to-back accesses are therefore legal.
- Arbitration:
  - Only one req high: that requester wins.
  - Both req high: the requester other than last_gnt wins. last_gnt updates on entering ACCESS.
  - conflict_cnt increments on each IDLE cycle with both req high, saturating at 255.
- Unselected requesters see no ack and must keep holding their request.
- Changing we/addr/wdata while req is high is a protocol violation; the latched values are used.
- ena=0:
  - All registers hold.
  - bank_en, bank_we and ack0/ack1 are forced 0.
  - An interrupted ACCESS or RESP completes when ena returns high; the request is not lost or duplicated.
- Reset values: state=IDLE, last_gnt=1 (port 0 wins the first tie), latches=0, conflict_cnt=0, all outputs 0.
- Reset mid-operation:
  - rst during ACCESS does not suppress that cycle's bank write, because bank strobes come from the state register.
  - No ack is issued; the requester must re-request after reset.
  - rst during RESP still outputs that cycle's ack.

Optional Feature:
- Macro SPI_ARB_LOCK_EN.
- When defined:
  - Inputs lock0 and lock1 (1 bit each) are added, sampled with the request.
  - If the winning request had lockN=1, the arbiter enters a locked mode: in following IDLE cycles only reqN is considered, the other req is ignored, and its conflict cycles are not counted.
  - The lock releases when port N completes an access with lockN=0.
  - rst clears the lock.
- When not defined: no lock ports, pure round-robin as above.

Test Plan:
- Single read, port 0: bank holds 0x5A at addr 1; req0=1, we0=0, addr0=1 at cycle 0 -> bank_en at cycle 1, ack0=1 with rdata0=0x5A at cycle 2, ack1 never asserted.
- Blocked write, port 1: req1 write addr1=5, wdata1=0xC4 -> bank_en=1 with bank_we=0 at cycle 1; ack1=1 and err1=1 at cycle 2; bank contents unchanged.
- Round-robin tie: both req high continuously after reset, writes 0x11 / 0x22 to addr 0 -> grants order 0,1,0,1; conflict_cnt increments each tie; final addr 0 value matches the last grant.
- Counter saturation: force 300 tie cycles -> conflict_cnt reads 255 and stays there.
- ena toggling: drop ena for 3 cycles during ACCESS -> no bank_en while low; exactly one bank_en and one ack once ena is restored; rdata correct.
- Reset mid-op: assert rst in the ACCESS cycle of a port 0 write of 0x33 to addr 0 -> bank write of 0x33 occurs, no ack0, state IDLE next cycle, conflict_cnt=0; with SPI_ARB_LOCK_EN, a locked port 1 loses its lock.

Source files
------------

// File: rtl/spi_reg_arbiter.sv
// spi_reg_arbiter: two-port round-robin arbiter/sequencer onto a single-port register bank.
// Optional build macro SPI_ARB_LOCK_EN adds lock0/lock1 for exclusive port ownership.

module spi_reg_arbiter_port #(
  parameter int REG_WIDTH = 8,
  parameter int PORT      = 0
) (
  input  logic                 resp_vld,
  input  logic                 gnt,
  input  logic                 wr_blk,
  input  logic [REG_WIDTH-1:0] bank_rdata,
  output logic                 ack,
  output logic                 err,
  output logic [REG_WIDTH-1:0] rdata
);
  assign ack   = resp_vld && (gnt == 1'(PORT));
  assign err   = ack && wr_blk;
  assign rdata = ack ? bank_rdata : '0;
endmodule

module spi_reg_arbiter #(
  parameter int REG_WIDTH = 8,
  parameter int ADDR_W    = 3,
  parameter int WR_LIMIT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [REG_WIDTH-1:0] wdata0,
  input  logic [REG_WIDTH-1:0] wdata1,
`ifdef SPI_ARB_LOCK_EN
  input  logic                 lock0,
  input  logic                 lock1,
`endif
  output logic                 ack0,
  output logic                 ack1,
  output logic [REG_WIDTH-1:0] rdata0,
  output logic [REG_WIDTH-1:0] rdata1,
  output logic                 err0,
  output logic                 err1,
  output logic                 bank_en,
  output logic                 bank_we,
  output logic [ADDR_W-1:0]    bank_addr,
  output logic [REG_WIDTH-1:0] bank_wdata,
  input  logic [REG_WIDTH-1:0] bank_rdata,
  output logic [7:0]           conflict_cnt
);
  localparam int NP = 2;
  localparam logic [ADDR_W:0] WR_LIM = WR_LIMIT[ADDR_W:0];

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t state, state_nx;

  logic [NP-1:0]                req_v, req_eff, we_v;
  logic [NP-1:0][ADDR_W-1:0]    addr_v;
  logic [NP-1:0][REG_WIDTH-1:0] wdata_v;
  logic [NP-1:0]                ack_v, err_v;
  logic [NP-1:0][REG_WIDTH-1:0] rdata_v;

  logic                 gnt, last_gnt, lat_we;
  logic [ADDR_W-1:0]    lat_addr;
  logic [REG_WIDTH-1:0] lat_wdata;
  logic                 tie, win, wr_ok, resp_vld;

  assign req_v   = {req1, req0};
  assign we_v    = {we1, we0};
  assign addr_v  = {addr1, addr0};
  assign wdata_v = {wdata1, wdata0};

`ifdef SPI_ARB_LOCK_EN
  logic [NP-1:0] lock_v;
  logic          lat_lock, lock_act, lock_port;

  assign lock_v = {lock1, lock0};

  // While locked, the other port is invisible: no grant, no conflict count.
  always_comb begin
    req_eff = req_v;
    if (lock_act) req_eff = lock_port ? {req_v[1], 1'b0} : {1'b0, req_v[0]};
  end

  // Lock state follows the lock bit of each completed access.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_lock  <= 1'b0;
      lock_act  <= 1'b0;
      lock_port <= 1'b0;
    end else if (ena) begin
      if (state == S_IDLE && |req_eff) lat_lock <= lock_v[win];
      if (state == S_RESP) begin
        lock_act  <= lat_lock;
        lock_port <= gnt;
      end
    end
  end
`else
  assign req_eff = req_v;
`endif

  assign tie   = &req_eff;
  assign win   = tie ? ~last_gnt : req_eff[1];
  assign wr_ok = {1'b0, lat_addr} < WR_LIM;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (ena) begin
      unique case (state)
        S_IDLE:   if (|req_eff) state_nx = S_ACCESS;
        S_ACCESS: state_nx = S_RESP;
        S_RESP:   state_nx = S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  // Strobes decode from the state register, so a reset in ACCESS still writes.
  always_comb begin
    bank_en  = 1'b0;
    bank_we  = 1'b0;
    resp_vld = 1'b0;
    if (ena) begin
      unique case (state)
        S_ACCESS: begin
          bank_en = 1'b1;
          bank_we = lat_we && wr_ok;
        end
        S_RESP:  resp_vld = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt          <= 1'b0;
      last_gnt     <= 1'b1;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      conflict_cnt <= '0;
    end else if (ena && state == S_IDLE) begin
      if (|req_eff) begin
        gnt       <= win;
        last_gnt  <= win;
        lat_we    <= we_v[win];
        lat_addr  <= addr_v[win];
        lat_wdata <= wdata_v[win];
      end
      if (tie && conflict_cnt != 8'hFF) conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

  assign bank_addr  = lat_addr;
  assign bank_wdata = lat_wdata;

  for (genvar p = 0; p < NP; p++) begin : g_port
    spi_reg_arbiter_port #(.REG_WIDTH(REG_WIDTH), .PORT(p)) u_port (
      .resp_vld   (resp_vld),
      .gnt        (gnt),
      .wr_blk     (lat_we && !wr_ok),
      .bank_rdata (bank_rdata),
      .ack        (ack_v[p]),
      .err        (err_v[p]),
      .rdata      (rdata_v[p])
    );
  end

  assign ack0   = ack_v[0];
  assign ack1   = ack_v[1];
  assign err0   = err_v[0];
  assign err1   = err_v[1];
  assign rdata0 = rdata_v[0];
  assign rdata1 = rdata_v[1];

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Bench for spi_reg_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_spi_reg_arbiter;
  localparam int RW = 8, AW = 3, WL = 2;

  logic clk = 1'b0;
  logic rst, ena, req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1, bank_addr;
  logic [RW-1:0] wdata0, wdata1, rdata0, rdata1, bank_wdata, bank_rdata;
  logic ack0, ack1, err0, err1, bank_en, bank_we;
  logic [7:0] conflict_cnt;
`ifdef SPI_ARB_LOCK_EN
  logic lock0, lock1;
`endif

  always #5 clk = ~clk;

  spi_reg_arbiter #(.REG_WIDTH(RW), .ADDR_W(AW), .WR_LIMIT(WL)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef SPI_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
    .conflict_cnt(conflict_cnt)
  );

  function automatic logic [RW-1:0] init_val(input int i);
    return (i == 1) ? 8'h5A : 8'(i * 17);
  endfunction

  // Read-first synchronous bank; rdata holds until the next access.
  logic [RW-1:0] bank_mem [8];
  bit mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 8; i++) bank_mem[i] <= init_val(i);
      bank_rdata <= '0;
    end else if (bank_en) begin
      bank_rdata <= bank_mem[bank_addr];
      if (bank_we) bank_mem[bank_addr] <= bank_wdata;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Requester agents
  bit          a_pend [2];
  bit          a_we   [2];
  logic [AW-1:0] a_addr [2];
  logic [RW-1:0] a_wdata[2];
  bit          a_lock [2];
  bit persist, rnd_mode;

  // Reference model: one in-flight transaction aged in enabled cycles
  bit            m_busy, m_we, m_lock;
  int            m_age, m_port, m_last, m_cnt, m_owner;
  logic [AW-1:0] m_addr;
  logic [RW-1:0] m_wdata, m_rexp;
  logic [RW-1:0] ref_mem [8];

  int ack_log[$];
  int n_ben, n_ack0;
  logic [RW-1:0] last_rd0;

  task automatic drive();
    req0 = a_pend[0]; we0 = a_we[0]; addr0 = a_addr[0]; wdata0 = a_wdata[0];
    req1 = a_pend[1]; we1 = a_we[1]; addr1 = a_addr[1]; wdata1 = a_wdata[1];
`ifdef SPI_ARB_LOCK_EN
    lock0 = a_lock[0]; lock1 = a_lock[1];
`endif
  endtask

  task automatic set_req(input int p, input bit we, input logic [AW-1:0] a,
                         input logic [RW-1:0] d, input bit lk);
    a_pend[p] = 1'b1; a_we[p] = we; a_addr[p] = a; a_wdata[p] = d; a_lock[p] = lk;
  endtask

  task automatic tick();
    bit e0, e1, eben, ebwe, blk, r0, r1, lk;
    int w;
    @(negedge clk);
    blk  = m_we && (m_addr >= AW'(WL));
    eben = ena && m_busy && m_age == 1;
    ebwe = eben && m_we && !blk;
    e0   = ena && m_busy && m_age == 2 && m_port == 0;
    e1   = ena && m_busy && m_age == 2 && m_port == 1;
    chk("ack0", ack0, e0);
    chk("ack1", ack1, e1);
    chk("bank_en", bank_en, eben);
    chk("bank_we", bank_we, ebwe);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    chk("err0", err0, e0 && blk);
    chk("err1", err1, e1 && blk);
    if (eben) chk("bank_addr", bank_addr, m_addr);
    if (ebwe) chk("bank_wdata", bank_wdata, m_wdata);
    if (e0) chk("rdata0", rdata0, m_rexp);
    if (e1) chk("rdata1", rdata1, m_rexp);
    if (ack0) begin ack_log.push_back(0); n_ack0++; last_rd0 = rdata0; end
    if (ack1) ack_log.push_back(1);
    if (bank_en) n_ben++;
    @(posedge clk);
    if (eben) begin
      m_rexp = ref_mem[m_addr];
      if (ebwe) ref_mem[m_addr] = m_wdata;
    end
    if (rst) begin
      m_busy = 1'b0; m_last = 1; m_cnt = 0; m_owner = -1;
    end else if (ena) begin
      if (m_busy) begin
        if (m_age == 2) begin
          m_busy  = 1'b0;
          m_owner = m_lock ? m_port : -1;
        end else m_age++;
      end else begin
        r0 = req0; r1 = req1;
        if (m_owner == 0) r1 = 1'b0;
        if (m_owner == 1) r0 = 1'b0;
        w = r1 ? 1 : 0;
        if (r0 && r1) begin
          w = 1 - m_last;
          if (m_cnt < 255) m_cnt++;
        end
        if (r0 || r1) begin
          m_busy = 1'b1; m_age = 1; m_port = w; m_last = w;
          m_we    = (w == 1) ? we1 : we0;
          m_addr  = (w == 1) ? addr1 : addr0;
          m_wdata = (w == 1) ? wdata1 : wdata0;
          lk = 1'b0;
`ifdef SPI_ARB_LOCK_EN
          lk = (w == 1) ? lock1 : lock0;
`endif
          m_lock = lk;
        end
      end
    end
    #1;
    if (e0 && !persist) a_pend[0] = 1'b0;
    if (e1 && !persist) a_pend[1] = 1'b0;
    if (rnd_mode) begin
      for (int p = 0; p < 2; p++)
        if (!a_pend[p] && $urandom_range(0, 2) == 0)
          set_req(p, 1'($urandom), AW'($urandom), RW'($urandom), $urandom_range(0, 3) == 0);
      ena = ($urandom_range(0, 7) != 0);
    end
    drive();
  endtask

  task automatic drain();
    int k = 0;
    while ((a_pend[0] || a_pend[1] || m_busy) && k < 80) begin tick(); k++; end
    chk("drain_done", 32'(a_pend[0] || a_pend[1] || m_busy), 0);
  endtask

  task automatic do_reset();
    a_pend[0] = 1'b0; a_pend[1] = 1'b0; a_lock[0] = 1'b0; a_lock[1] = 1'b0;
    persist = 1'b0; ena = 1'b1; rst = 1'b1;
    drive();
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      a_pend[p] = 0; a_we[p] = 0; a_addr[p] = '0; a_wdata[p] = '0; a_lock[p] = 0;
    end
    persist = 0; rnd_mode = 0; mem_init = 1; rst = 1; ena = 1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    mem_init = 0; rst = 0;
    for (int i = 0; i < 8; i++) ref_mem[i] = init_val(i);
    m_busy = 0; m_last = 1; m_cnt = 0; m_owner = -1; m_age = 0; m_port = 0;
    m_we = 0; m_lock = 0; m_addr = '0; m_wdata = '0; m_rexp = '0;
    n_ben = 0; n_ack0 = 0; last_rd0 = '0;
    #1;
    chk("rst_cnt", conflict_cnt, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_bank_en", bank_en, 0);

    // single read, port 0
    set_req(0, 0, 3'd1, 8'h00, 0); drive();
    tick(); #1;
    chk("rd_bank_en_c1", bank_en, 1);
    chk("rd_ack0_c1", ack0, 0);
    tick(); #1;
    chk("rd_ack0_c2", ack0, 1);
    chk("rd_data_c2", rdata0, 8'h5A);
    chk("rd_ack1_c2", ack1, 0);
    tick();

    // blocked write, port 1
    set_req(1, 1, 3'd5, 8'hC4, 0); drive();
    tick(); #1;
    chk("bw_bank_en", bank_en, 1);
    chk("bw_bank_we", bank_we, 0);
    tick(); #1;
    chk("bw_ack1", ack1, 1);
    chk("bw_err1", err1, 1);
    tick(); tick();
    chk("bw_mem5", bank_mem[5], 8'h55);

    // round-robin tie
    do_reset();
    persist = 1;
    set_req(0, 1, 3'd0, 8'h11, 0); set_req(1, 1, 3'd0, 8'h22, 0); drive();
    ack_log.delete();
    for (int k = 0; k < 40 && ack_log.size() < 4; k++) tick();
    #1;
    chk("rr_grants", 32'(ack_log.size() >= 4), 1);
    for (int k = 0; k < 4 && k < ack_log.size(); k++) chk("rr_order", ack_log[k], k % 2);
    chk("rr_cnt", conflict_cnt, 4);
    chk("rr_mem0", bank_mem[0], 8'h22);
    persist = 0;
    drain();

    // counter saturation
    do_reset();
    persist = 1;
    set_req(0, 0, 3'd2, 8'h00, 0); set_req(1, 0, 3'd3, 8'h00, 0); drive();
    repeat (920) tick();
    chk("sat_cnt", conflict_cnt, 255);
    repeat (30) tick();
    chk("sat_hold", conflict_cnt, 255);
    persist = 0;
    drain();

    // ena dropped during ACCESS
    do_reset();
    set_req(0, 0, 3'd1, 8'h00, 0); drive();
    tick();
    ena = 0; n_ben = 0;
    repeat (3) tick();
    chk("ena_lo_ben", n_ben, 0);
    ena = 1; n_ack0 = 0;
    repeat (6) tick();
    chk("ena_ben_once", n_ben, 1);
    chk("ena_ack_once", n_ack0, 1);
    chk("ena_rdata", last_rd0, 8'h5A);

    // reset in ACCESS of a port 0 write
    do_reset();
    set_req(0, 1, 3'd0, 8'h33, 0); drive();
    tick();
    rst = 1; n_ack0 = 0;
    #1;
    chk("rm_bank_we", bank_we, 1);
    tick();
    rst = 0;
    #1;
    chk("rm_mem0", bank_mem[0], 8'h33);
    chk("rm_cnt", conflict_cnt, 0);
    chk("rm_idle_ben", bank_en, 0);
    chk("rm_no_ack", n_ack0, 0);
    drain();

`ifdef SPI_ARB_LOCK_EN
    do_reset();
    set_req(1, 0, 3'd4, 8'h00, 1); drive();
    drain();
    set_req(0, 0, 3'd2, 8'h00, 0); set_req(1, 0, 3'd3, 8'h00, 0); drive();
    ack_log.delete();
    drain();
    chk("lk_n", 32'(ack_log.size() >= 2), 1);
    if (ack_log.size() >= 2) begin
      chk("lk_first", ack_log[0], 1);
      chk("lk_second", ack_log[1], 0);
    end
    set_req(1, 0, 3'd4, 8'h00, 1); drive();
    drain();
    rst = 1; tick(); rst = 0;
    set_req(0, 0, 3'd2, 8'h00, 0); set_req(1, 0, 3'd3, 8'h00, 0); drive();
    ack_log.delete();
    drain();
    chk("lk_rst_n", 32'(ack_log.size() >= 1), 1);
    if (ack_log.size() >= 1) chk("lk_rst_first", ack_log[0], 0);
`endif

    // random traffic
    do_reset();
    rnd_mode = 1;
    repeat (1500) tick();
    rnd_mode = 0; ena = 1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
